// File: rtl/cpu6_pipeline_drain_ctrl_pkg.sv
// cpu6_pipeline_drain_ctrl_pkg: drain sequencer state encoding, default widths and width helper
package cpu6_pipeline_drain_ctrl_pkg;
    localparam int CPU6_DRAIN_STATE_W = 2;
    localparam int DEF_OUTST_W = 3;
    localparam int DEF_TIMEOUT = 1024;

    typedef enum logic [CPU6_DRAIN_STATE_W-1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        WBWAIT = 2'd2,
        DONE   = 2'd3
    } drain_state_t;

    // Bits needed to hold 0..n; never narrower than one bit so a zero limit still builds.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    localparam int DEF_WD_W = cnt_w(DEF_TIMEOUT);
endpackage

// File: rtl/cpu6_pipeline_drain_ctrl_if.sv
// cpu6_pipeline_drain_ctrl_if: pipeline/LSU handshake bundle between the core and the drain sequencer
interface cpu6_pipeline_drain_ctrl_if
    import cpu6_pipeline_drain_ctrl_pkg::*;
#(
    parameter int OUTST_W = DEF_OUTST_W
);
    logic               empty_pipeline_reqD;
    logic               stall_ext;
    logic               empty_pipeline_reqM;
    logic               flush_req;
    logic               lsu_req_fire;
    logic               lsu_resp_fire;
    logic               stallF;
    logic               stallD;
    logic               flushE;
    logic               drain_busy;
    logic               drain_done;
    logic [OUTST_W-1:0] outst_cnt;
    logic               err_underflow;
    logic               err_timeout;

    modport slave (
        input  empty_pipeline_reqD, stall_ext, empty_pipeline_reqM, flush_req, lsu_req_fire, lsu_resp_fire,
        output stallF, stallD, flushE, drain_busy, drain_done, outst_cnt, err_underflow, err_timeout
    );

    modport master (
        output empty_pipeline_reqD, stall_ext, empty_pipeline_reqM, flush_req, lsu_req_fire, lsu_resp_fire,
        input  stallF, stallD, flushE, drain_busy, drain_done, outst_cnt, err_underflow, err_timeout
    );
endinterface

// File: rtl/cpu6_pipeline_drain_ctrl_updown_cnt.sv
// cpu6_updown_cnt: saturating up/down counter with a sticky underflow flag
module cpu6_updown_cnt #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next,
    output logic         underflow
);
    localparam logic [W-1:0] MAX = '1;

    // Saturate at both ends; simultaneous inc/dec cancel out.
    always_comb cnt_next = (inc & ~dec) ? ((cnt == MAX) ? cnt : cnt + W'(1)) :
                           (dec & ~inc) ? ((cnt == '0) ? cnt : cnt - W'(1)) : cnt;

    // Count register and sticky flag for a decrement seen at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            underflow <= 1'b0;
        end else begin
            cnt       <= cnt_next;
            underflow <= underflow | (dec & ~inc & (cnt == '0));
        end
    end
endmodule

// File: rtl/cpu6_pipeline_drain_ctrl.sv
// cpu6_pipeline_drain_ctrl: stalls the front end and drains the pipeline and LSU for a requesting instruction
module cpu6_pipeline_drain_ctrl
    import cpu6_pipeline_drain_ctrl_pkg::*;
#(
    parameter int OUTST_W = DEF_OUTST_W,
    parameter int WB_LAT  = 2,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    cpu6_pipeline_drain_ctrl_if.slave bus
);
    localparam int WBW = cnt_w(WB_LAT);
    localparam int WDW = cnt_w(TIMEOUT);
    localparam logic [WBW-1:0] WB_INIT = WBW'((WB_LAT > 0) ? WB_LAT - 1 : 0);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    drain_state_t       state, state_n;
    logic               seen_m, seen_n;
    logic [WBW-1:0]     wb_cnt, wb_n;
    logic [WDW-1:0]     wd_cnt, wd_n;
    logic               to_set;
    logic               err_timeout;
    logic [OUTST_W-1:0] cnt, cnt_next;
    logic               underflow;

    cpu6_updown_cnt #(.W(OUTST_W)) u_outst (
        .clk       (clk),
        .reset     (reset),
        .inc       (bus.lsu_req_fire),
        .dec       (bus.lsu_resp_fire),
        .cnt       (cnt),
        .cnt_next  (cnt_next),
        .underflow (underflow)
    );

    // Next state: completion uses the post-update LSU count; an abort is only possible before MEM was seen.
    always_comb begin
        state_n = state;
        seen_n  = seen_m;
        wb_n    = wb_cnt;
        wd_n    = '0;
        to_set  = 1'b0;
        unique case (state)
            IDLE: begin
                seen_n = 1'b0;
                if (bus.empty_pipeline_reqD & ~bus.stall_ext & ~bus.flush_req) state_n = DRAIN;
            end
            DRAIN: begin
                seen_n = seen_m | bus.empty_pipeline_reqM;
                wd_n   = wd_cnt + WDW'(1);
                if (bus.flush_req & ~seen_m) begin
                    state_n = IDLE;
                    seen_n  = 1'b0;
                end else if (seen_n && cnt_next == '0) begin
                    state_n = (WB_LAT == 0) ? DONE : WBWAIT;
                    wb_n    = WB_INIT;
                    seen_n  = 1'b0;
                end else if (TIMEOUT != 0 && wd_cnt == WD_LAST) begin
                    state_n = DONE;
                    to_set  = 1'b1;
                    seen_n  = 1'b0;
                end
            end
            WBWAIT: begin
                if (wb_cnt == '0) state_n = DONE;
                else wb_n = wb_cnt - WBW'(1);
            end
            DONE: state_n = IDLE;
        endcase
    end

    // State, MEM-seen latch, writeback and watchdog counters, sticky timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            seen_m      <= 1'b0;
            wb_cnt      <= '0;
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            seen_m      <= seen_n;
            wb_cnt      <= wb_n;
            wd_cnt      <= wd_n;
            err_timeout <= err_timeout | to_set;
        end
    end

    assign bus.stallF        = (state == DRAIN) | (state == WBWAIT);
    assign bus.stallD        = bus.stallF;
    assign bus.flushE        = bus.stallF;
    assign bus.drain_busy    = state != IDLE;
    assign bus.drain_done    = state == DONE;
    assign bus.outst_cnt     = cnt;
    assign bus.err_underflow = underflow;
    assign bus.err_timeout   = err_timeout;
endmodule

// File: tb/tb_cpu6_pipeline_drain_ctrl.sv
// tb_cpu6_pipeline_drain_ctrl: table-driven directed checks of the drain sequencer plus watchdog and reset sequences
module tb_cpu6_pipeline_drain_ctrl;
    localparam logic [5:0] RD = 6'b100000;
    localparam logic [5:0] SX = 6'b010000;
    localparam logic [5:0] RM = 6'b001000;
    localparam logic [5:0] FL = 6'b000100;
    localparam logic [5:0] LQ = 6'b000010;
    localparam logic [5:0] LR = 6'b000001;

    typedef struct {
        logic [5:0] in;
        logic [9:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    vec_t tbl[$];

    cpu6_pipeline_drain_ctrl_if #(.OUTST_W(3)) bus ();

    cpu6_pipeline_drain_ctrl #(.OUTST_W(3), .WB_LAT(2), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] e(input logic st, input logic b, input logic d,
                                     input logic [2:0] c, input logic eu, input logic et);
        return {st, st, st, b, d, c, eu, et};
    endfunction

    function automatic vec_t v(input logic [5:0] i, input logic [9:0] x);
        vec_t r;
        r.in  = i;
        r.exp = x;
        return r;
    endfunction

    function automatic logic [9:0] obs();
        return {bus.stallF, bus.stallD, bus.flushE, bus.drain_busy, bus.drain_done,
                bus.outst_cnt, bus.err_underflow, bus.err_timeout};
    endfunction

    task automatic drive(input logic [5:0] i);
        {bus.empty_pipeline_reqD, bus.stall_ext, bus.empty_pipeline_reqM,
         bus.flush_req, bus.lsu_req_fire, bus.lsu_resp_fire} = i;
    endtask

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got sF/sD/fE/busy/done/cnt/eu/et=%b, expected %b", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [5:0] i, input logic [9:0] x, input string nm);
        drive(i);
        #2;
        check(nm, obs(), x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // basic drain: accept, reqM two cycles later, WB_LAT=2
        tbl.push_back(v(RD, e(0,0,0,0,0,0)));
        tbl.push_back(v(0,  e(1,1,0,0,0,0)));
        tbl.push_back(v(RM, e(1,1,0,0,0,0)));
        tbl.push_back(v(0,  e(1,1,0,0,0,0)));
        tbl.push_back(v(0,  e(1,1,0,0,0,0)));
        tbl.push_back(v(0,  e(0,1,1,0,0,0)));
        tbl.push_back(v(0,  e(0,0,0,0,0,0)));
        // request blocked by stall_ext, then by flush
        tbl.push_back(v(RD | SX, e(0,0,0,0,0,0)));
        tbl.push_back(v(RD | FL, e(0,0,0,0,0,0)));
        tbl.push_back(v(0,       e(0,0,0,0,0,0)));
        // outstanding loads: three issued, responses later, flush after reqM ignored
        tbl.push_back(v(LQ, e(0,0,0,0,0,0)));
        tbl.push_back(v(LQ, e(0,0,0,1,0,0)));
        tbl.push_back(v(LQ, e(0,0,0,2,0,0)));
        tbl.push_back(v(RD, e(0,0,0,3,0,0)));
        tbl.push_back(v(0,  e(1,1,0,3,0,0)));
        tbl.push_back(v(RM, e(1,1,0,3,0,0)));
        tbl.push_back(v(FL, e(1,1,0,3,0,0)));
        tbl.push_back(v(LR, e(1,1,0,3,0,0)));
        tbl.push_back(v(0,  e(1,1,0,2,0,0)));
        tbl.push_back(v(LR, e(1,1,0,2,0,0)));
        tbl.push_back(v(0,  e(1,1,0,1,0,0)));
        tbl.push_back(v(0,  e(1,1,0,1,0,0)));
        tbl.push_back(v(LR, e(1,1,0,1,0,0)));
        tbl.push_back(v(0,  e(1,1,0,0,0,0)));
        tbl.push_back(v(0,  e(1,1,0,0,0,0)));
        tbl.push_back(v(0,  e(0,1,1,0,0,0)));
        tbl.push_back(v(0,  e(0,0,0,0,0,0)));
        // abort before reqM, fresh accept, flush in WBWAIT ignored, reqD in DONE deferred
        tbl.push_back(v(RD, e(0,0,0,0,0,0)));
        tbl.push_back(v(FL, e(1,1,0,0,0,0)));
        tbl.push_back(v(0,  e(0,0,0,0,0,0)));
        tbl.push_back(v(0,  e(0,0,0,0,0,0)));
        tbl.push_back(v(RD, e(0,0,0,0,0,0)));
        tbl.push_back(v(0,  e(1,1,0,0,0,0)));
        tbl.push_back(v(RM, e(1,1,0,0,0,0)));
        tbl.push_back(v(FL, e(1,1,0,0,0,0)));
        tbl.push_back(v(0,  e(1,1,0,0,0,0)));
        tbl.push_back(v(RD, e(0,1,1,0,0,0)));
        tbl.push_back(v(RD, e(0,0,0,0,0,0)));
        tbl.push_back(v(0,  e(1,1,0,0,0,0)));
        tbl.push_back(v(RM, e(1,1,0,0,0,0)));
        tbl.push_back(v(0,  e(1,1,0,0,0,0)));
        tbl.push_back(v(0,  e(1,1,0,0,0,0)));
        tbl.push_back(v(0,  e(0,1,1,0,0,0)));
        tbl.push_back(v(0,  e(0,0,0,0,0,0)));
        // simultaneous req/resp, then underflow
        tbl.push_back(v(LQ,      e(0,0,0,0,0,0)));
        tbl.push_back(v(LQ | LR, e(0,0,0,1,0,0)));
        tbl.push_back(v(LR,      e(0,0,0,1,0,0)));
        tbl.push_back(v(LR,      e(0,0,0,0,0,0)));
        tbl.push_back(v(0,       e(0,0,0,0,1,0)));
        tbl.push_back(v(0,       e(0,0,0,0,1,0)));

        drive(0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs(), 10'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) cyc(tbl[i].in, tbl[i].exp, $sformatf("row%0d", i));

        // saturation at 7 and count back down; underflow stays sticky
        for (int k = 0; k < 9; k++) cyc(LQ, e(0,0,0,3'((k > 7) ? 7 : k),1,0), $sformatf("sat_up%0d", k));
        cyc(0, e(0,0,0,7,1,0), "sat_hold");
        for (int k = 0; k < 7; k++) cyc(LR, e(0,0,0,3'(7 - k),1,0), $sformatf("sat_dn%0d", k));
        cyc(0, e(0,0,0,0,1,0), "sat_zero");

        // watchdog: reqM never arrives, 16 DRAIN cycles then forced DONE
        cyc(RD, e(0,0,0,0,1,0), "wd_accept");
        for (int k = 1; k <= 16; k++) cyc(0, e(1,1,0,0,1,0), $sformatf("wd_drain%0d", k));
        cyc(0, e(0,1,1,0,1,1), "wd_done");
        cyc(0, e(0,0,0,0,1,1), "wd_idle");

        // asynchronous reset during WBWAIT
        cyc(RD, e(0,0,0,0,1,1), "rst_accept");
        cyc(RM, e(1,1,0,0,1,1), "rst_drain");
        cyc(LQ, e(1,1,0,0,1,1), "rst_wbwait0");
        drive(0);
        #2;
        check("rst_wbwait1", obs(), e(1,1,0,1,1,1));
        #1;
        reset = 1'b0;
        #1;
        check("rst_async", obs(), 10'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        cyc(0, e(0,0,0,0,0,0), "rst_idle");
        cyc(RD, e(0,0,0,0,0,0), "post_rst_accept");
        cyc(0, e(1,1,0,0,0,0), "post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu6_pipeline_drain_ctrl.md
Name: cpu6_pipeline_drain_ctrl

Overview:
Sequencer that empties the cpu6 pipeline when an instruction needs it, such as a CSR write or fence-like op carrying empty_pipeline_req. It sits beside the hazard unit.
- Holds F/D and injects bubbles into E so that nothing younger follows the requester.
- Waits for the requester to reach MEM and for all outstanding LSU transactions to retire.
- Waits out the writeback latency, then pulses done and releases the stall.
- Aborts cleanly if the requester is flushed.

Parameters:
OUTST_W, 3, width of the outstanding-LSU-transaction counter (max 7 in flight).
WB_LAT, 2, cycles between the MEM-stage condition met and the architectural state being safe.
TIMEOUT, 1024, watchdog limit in cycles spent in DRAIN; 0 disables it.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset
empty_pipeline_reqD  in  1  valid instruction in D requests a drain
stall_ext  in  1  other hazard stall of D this cycle; the requester does not advance
empty_pipeline_reqM  in  1  requester is in MEM (output of the EX/MEM register)
flush_req  in  1  trap/redirect kills D/E/M contents this cycle
lsu_req_fire  in  1  LSU transaction issued
lsu_resp_fire  in  1  LSU transaction completed
stallF  out  1  hold PC
stallD  out  1  hold the IF/ID register
flushE  out  1  bubble into the ID/EX register
drain_busy  out  1  state != IDLE
drain_done  out  1  one-cycle pulse, drain complete
outst_cnt  out  OUTST_W  current outstanding LSU count
err_underflow  out  1  sticky: response received while the count was 0
err_timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset (async, reset=0): state=IDLE, all outputs 0, counters 0, sticky errors cleared.
- Outstanding counter runs in every state:
  - req only: +1, saturating at 2^OUTST_W-1.
  - resp only: -1.
  - req and resp together: unchanged.
  - resp at 0: stays 0 and sets err_underflow.
- States (registered); stall/flush outputs are decoded from the state:
  - IDLE: outputs 0.
    - empty_pipeline_reqD & ~stall_ext & ~flush_req -> DRAIN. The requester advances into E this edge.
  - DRAIN: stallF=stallD=flushE=1.
    - Latch seenM when empty_pipeline_reqM=1.
    - seenM & outst_cnt==0 (evaluated with the next-count value) -> WBWAIT, loading wb_cnt=WB_LAT-1.
    - If WB_LAT=0, go -> DONE instead.
  - WBWAIT: stallF=stallD=flushE=1.
    - wb_cnt decrements; at 0 -> DONE.
  - DONE: drain_done=1 for exactly one cycle, stalls deasserted this cycle -> IDLE.
    - A new empty_pipeline_reqD in DONE is not accepted; it is taken next cycle from IDLE.
- flush_req in DRAIN before seenM: abort -> IDLE, no drain_done, seenM cleared, outst_cnt kept.
- flush_req in DRAIN after seenM, or in WBWAIT/DONE: ignored. The requester has already passed the flush point.
- Watchdog: counts cycles in DRAIN. On reaching TIMEOUT: set err_timeout and force -> DONE, so the core is never hung.
- Minimum latency, with no LSU traffic and WB_LAT=2:
  - accept at edge 0, reqM at cycle 2 -> WBWAIT at cycle 3;
  - drain_done at cycle 5; stallF low in cycle 5.
- Asserting reset mid-drain returns to IDLE immediately and releases the stalls asynchronously.

Decomposition:
- cpu6_defines additions:
  - CPU6_DRAIN_STATE_W=2;
  - state encodings IDLE=0, DRAIN=1, WBWAIT=2, DONE=3;
  - default widths for OUTST_W and the watchdog counter (clog2 of TIMEOUT+1).
- One natural sub-module: cpu6_updown_cnt, a saturating up/down counter with an underflow flag. It is reused for outst_cnt.
- State and counters use async-reset flops (cpu6_dffr-style, active-low variant).

Test Plan:
- Basic drain: reqD=1 at cycle 0, reqM=1 at cycle 2, no LSU, WB_LAT=2 -> stallF/stallD/flushE high on cycles 1-4, drain_done=1 only at cycle 5, drain_busy high on cycles 1-5.
- Outstanding loads: 3 lsu_req_fire before accept, responses at cycles 4, 6, 9, reqM at cycle 2 -> WBWAIT entered at cycle 10, drain_done at cycle 12, outst_cnt reads 3,2,1,0 at the matching cycles.
- Simultaneous fire: req and resp in the same cycle with count=1 -> count stays 1. Resp with count 0 -> count 0, err_underflow=1 and stays 1 until reset.
- Abort: flush_req at cycle 1 (before reqM) -> IDLE at cycle 2, stalls low, no drain_done. A fresh reqD at cycle 4 is accepted normally.
- Watchdog: TIMEOUT=16, reqM never asserted -> err_timeout=1 after 16 DRAIN cycles, DONE pulse the next cycle, back to IDLE.
- Reset mid-drain: reset=0 asynchronously during WBWAIT -> all outputs 0 before the next clk edge; after release, the block is in IDLE with counters 0.
